// File: rtl/tmds_pkg.sv
// Shared TMDS constants, the stage-1 pipeline word and small helper functions.
`timescale 1ns/1ps
`default_nettype none

package tmds_pkg;
  localparam int C_tmds_bits = 10;
  localparam int C_cnt_bits  = 5;

  localparam logic [C_tmds_bits-1:0] C_tok_00 = 10'b1101010100;
  localparam logic [C_tmds_bits-1:0] C_tok_01 = 10'b0010101011;
  localparam logic [C_tmds_bits-1:0] C_tok_10 = 10'b0101010100;
  localparam logic [C_tmds_bits-1:0] C_tok_11 = 10'b1010101011;

  typedef struct packed {
    logic [8:0] qm;
    logic       blank;
    logic       c1;
    logic       c0;
  } qm_word_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [C_tmds_bits-1:0] ctrl_token(input logic c1, input logic c0);
    logic [C_tmds_bits-1:0] t;
    case ({c1, c0})
      2'b00:   t = C_tok_00;
      2'b01:   t = C_tok_01;
      2'b10:   t = C_tok_10;
      default: t = C_tok_11;
    endcase
    return t;
  endfunction
endpackage

`default_nettype wire

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: builds q_m from the data byte, optionally registered
// together with the blank and control bits.
`timescale 1ns/1ps
`default_nettype none

module tmds_qm_stage
  import tmds_pkg::*;
#(
  parameter bit C_register = 1'b1
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       c0_i,
  input  logic       c1_i,
  input  logic       blank_i,
  output qm_word_t   word_o
);

  logic [3:0] n1d;
  logic       use_xnor;
  qm_word_t   word_d;

  always_comb begin
    n1d      = popcount8(data_i);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_i[0]);
    word_d.qm[0] = data_i[0];
    for (int i = 1; i < 8; i++) begin
      word_d.qm[i] = use_xnor ? ~(word_d.qm[i-1] ^ data_i[i]) : (word_d.qm[i-1] ^ data_i[i]);
    end
    word_d.qm[8] = ~use_xnor;
    word_d.blank = blank_i;
    word_d.c1    = c1_i;
    word_d.c0    = c0_i;
  end

  generate
    if (C_register) begin : g_reg
      qm_word_t word_q;
      // Blank resets high so the first symbol after reset is a control token.
      always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= '{qm: '0, blank: 1'b1, c1: 1'b0, c0: 1'b0};
        end else begin
          word_q <= word_d;
        end
      end
      assign word_o = word_q;
    end else begin : g_comb
      assign word_o = word_d;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/tmds_encoder_pipelined.sv
// Single-lane DVI/TMDS 8b/10b encoder: q_m stage followed by the DC-balance
// stage that owns the running disparity counter and the output register.
`timescale 1ns/1ps
`default_nettype none

module tmds_encoder_pipelined
  import tmds_pkg::*;
#(
  parameter int C_pipe_stages = 2
) (
  input  logic                   clk_pixel,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_c0,
  input  logic                   in_c1,
  input  logic                   in_blank,
  output logic [C_tmds_bits-1:0] out_tmds
);

  generate
    if ((C_pipe_stages != 1) && (C_pipe_stages != 2)) begin : g_bad_pipe_stages
      $error("tmds_encoder_pipelined: C_pipe_stages must be 1 or 2");
    end
  endgenerate

  localparam logic signed [C_cnt_bits-1:0] C_two   = 5'sd2;
  localparam logic signed [C_cnt_bits-1:0] C_eight = 5'sd8;

  qm_word_t                      s1;
  logic                          q8;
  logic [3:0]                    n1;
  logic signed [C_cnt_bits-1:0]  diff;
  logic signed [C_cnt_bits-1:0]  cnt_q, cnt_d;
  logic [C_tmds_bits-1:0]        out_q, out_d;

  tmds_qm_stage #(
    .C_register (C_pipe_stages == 2)
  ) u_qm (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data_i    (in_data),
    .c0_i      (in_c0),
    .c1_i      (in_c1),
    .blank_i   (in_blank),
    .word_o    (s1)
  );

  // diff = N1 - N0; counter math is mod 32, the true result always lies in -8..+8.
  always_comb begin
    q8    = s1.qm[8];
    n1    = popcount8(s1.qm[7:0]);
    diff  = $signed({n1, 1'b0}) - C_eight;
    out_d = out_q;
    cnt_d = cnt_q;
    if (s1.blank) begin
      out_d = ctrl_token(s1.c1, s1.c0);
      cnt_d = '0;
    end else if ((cnt_q == '0) || (n1 == 4'd4)) begin
      out_d = {~q8, q8, q8 ? s1.qm[7:0] : ~s1.qm[7:0]};
      cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((!cnt_q[C_cnt_bits-1] && (n1 > 4'd4)) ||
                 ( cnt_q[C_cnt_bits-1] && (n1 < 4'd4))) begin
      out_d = {1'b1, q8, ~s1.qm[7:0]};
      cnt_d = cnt_q + (q8 ? C_two : '0) - diff;
    end else begin
      out_d = {1'b0, q8, s1.qm[7:0]};
      cnt_d = cnt_q - (q8 ? '0 : C_two) + diff;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= C_tok_00;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_tmds = out_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_encoder_pipelined.sv
// Self-checking bench for tmds_encoder_pipelined: directed vector table, then a
// long random stream compared against a behavioural encoder model.
`timescale 1ns/1ps
`default_nettype none

module tb_tmds_encoder_pipelined;

  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_c0     = 1'b0;
  logic       in_c1     = 1'b0;
  logic       in_blank  = 1'b1;
  logic [9:0] out_tmds;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       c1;
    logic       c0;
    logic       blank;
  } in_t;

  typedef struct {
    logic [7:0] data;
    logic       c1;
    logic       c0;
    logic       blank;
    logic [9:0] exp_out;
    int         exp_cnt;
  } vec_t;

  in_t  pipe_q[$];
  int   m_cnt;
  vec_t vec[12];

  tmds_encoder_pipelined #(.C_pipe_stages(2)) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_c0     (in_c0),
    .in_c1     (in_c1),
    .in_blank  (in_blank),
    .out_tmds  (out_tmds)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural encoder written directly from the TMDS rules with integer arithmetic.
  function automatic logic [9:0] model_sym(input in_t x);
    logic [8:0] qm;
    logic [9:0] s;
    int n1d, n1, n0;
    bit xnor_path;
    if (x.blank) begin
      m_cnt = 0;
      case ({x.c1, x.c0})
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      return s;
    end
    n1d = $countones(x.data);
    xnor_path = (n1d > 4) || (n1d == 4 && x.data[0] == 1'b0);
    qm[0] = x.data[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xnor_path ? ~(qm[i-1] ^ x.data[i]) : (qm[i-1] ^ x.data[i]);
    qm[8] = !xnor_path;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (m_cnt == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      m_cnt += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      m_cnt += -2 * (qm[8] ? 0 : 1) + n1 - n0;
    end
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic model_reset();
    in_t b;
    b = '{8'h00, 1'b0, 1'b0, 1'b1};
    pipe_q.delete();
    pipe_q.push_back(b);
    m_cnt = 0;
  endtask

  task automatic drive(input logic [7:0] d, input logic c1, input logic c0, input logic b);
    in_data = d; in_c1 = c1; in_c0 = c0; in_blank = b;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic step(input logic [7:0] d, input logic c1, input logic c0, input logic b);
    in_t cur, old;
    logic [9:0] exp;
    int cnt_act;
    cur = '{d, c1, c0, b};
    drive(d, c1, c0, b);
    old = pipe_q.pop_front();
    pipe_q.push_back(cur);
    exp = model_sym(old);
    cnt_act = dut.cnt_q;
    chk("out_tmds", int'(out_tmds), int'(exp));
    chk("cnt", cnt_act, m_cnt);
    chk("cnt_range", (cnt_act >= -8 && cnt_act <= 8) ? 1 : 0, 1);
    if (!old.blank) chk("decode", int'(decode(out_tmds)), int'(old.data));
  endtask

  // Reset pulse landing between clock edges; output must clear without an edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", int'(out_tmds), 'h354);
    chk("async_rst_cnt", int'(dut.cnt_q), 0);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int burst;

    vec[0]  = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354,  0};
    vec[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 10'h0AB,  0};
    vec[2]  = '{8'h00, 1'b1, 1'b0, 1'b1, 10'h154,  0};
    vec[3]  = '{8'h00, 1'b1, 1'b1, 1'b1, 10'h2AB,  0};
    vec[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h100, -8};
    vec[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h3FF,  2};
    vec[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h100, -6};
    vec[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h3FF,  4};
    vec[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354,  0};
    vec[9]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 10'h200, -8};
    vec[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354,  0};
    vec[11] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10'h200, -8};

    #12;
    chk("reset_out", int'(out_tmds), 'h354);
    chk("reset_cnt", int'(dut.cnt_q), 0);
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    chk("post_release_out", int'(out_tmds), 'h354);

    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(vec[i].data, vec[i].c1, vec[i].c0, vec[i].blank);
      else        drive(8'h00, 1'b0, 1'b0, 1'b1);
      if (i > 0) begin
        chk($sformatf("vec%0d_out", i - 1), int'(out_tmds), int'(vec[i-1].exp_out));
        chk($sformatf("vec%0d_cnt", i - 1), int'(dut.cnt_q), vec[i-1].exp_cnt);
      end
    end

    mid_reset();
    burst = 0;
    for (int n = 0; n < 10000; n++) begin
      if (n == 3000 || n == 7000) mid_reset();
      if (burst == 0 && $urandom_range(15) == 0) burst = $urandom_range(4, 1);
      if (burst > 0) begin
        step(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        burst--;
      end else begin
        step(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
